control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Control sequencer: fetch/decode/execute FSM that drives the datapath select
// lines, the memory handshake and the PC update, with a bus-wait timeout that
// parks the block in a sticky FAULT state until reset.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   FETCH  | request instruction at PC, load IR on ack
//   DECODE | one idle cycle, dispatch on fmt
//   ALU    | register/immediate ALU operation with write-back
//   MEM    | load (fmt 01) or store (fmt 10), address = rs1 + imm
//   BRANCH | evaluate condition on status, load target if taken
//   PCINC  | advance PC to the next instruction
//   FAULT  | bus timeout, sticky until rst
module control_sequencer #(
    parameter int IR_W     = 16,
    parameter int REG_AW   = 3,
    parameter int WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [3:0]        status,
    input  logic              mem_ack,
    output logic [REG_AW-1:0] a_sel,
    output logic [REG_AW-1:0] b_sel,
    output logic [REG_AW-1:0] d_sel,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [3:0]        alu_op,
    output logic              alu_b_imm,
    output logic              psr_we,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_sel,
    output logic              addr_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic              fault,
    output logic [6:0]        state_o
);

    // A zero WAIT_MAX still needs a 1-bit counter so the logic stays legal.
    localparam int WCW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = (WAIT_MAX > 0) ? WCW'(WAIT_MAX - 1) : '0;

    generate
        if (IR_W < 3 * REG_AW + 7) begin : g_ir_w_check
            $error("control_sequencer: IR_W must be at least 3*REG_AW+7");
        end
    endgenerate

    typedef enum logic [6:0] {
        FETCH  = 7'b0000001,
        DECODE = 7'b0000010,
        ALU    = 7'b0000100,
        MEM    = 7'b0001000,
        BRANCH = 7'b0010000,
        PCINC  = 7'b0100000,
        FAULT  = 7'b1000000
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IR_W-1:0]   ir;
    logic [WCW-1:0]    wait_cnt;

    logic [1:0]        fmt;
    logic [3:0]        op;
    logic              imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;

    logic              flag_n;
    logic              flag_z;
    logic              flag_v;
    logic              unused_flag_c;
    logic              taken;
    logic              timeout;

    assign fmt = ir[IR_W-1 -: 2];
    assign op  = ir[IR_W-3 -: 4];
    assign imm = ir[3*REG_AW];
    assign rd  = ir[3*REG_AW-1 -: REG_AW];
    assign rs1 = ir[2*REG_AW-1 -: REG_AW];
    assign rs2 = ir[REG_AW-1:0];

    assign flag_n        = status[3];
    assign flag_z        = status[2];
    assign flag_v        = status[1];
    assign unused_flag_c = status[0];

    // An ack in the last allowed cycle suppresses the timeout.
    assign timeout = (WAIT_MAX != 0) && (wait_cnt == WAIT_LAST) && !mem_ack;

    // Branch condition decode on op.
    always_comb begin
        taken = 1'b0;
        case (op)
            4'd0:    taken = 1'b1;
            4'd1:    taken = flag_z;
            4'd2:    taken = !flag_z;
            4'd3:    taken = flag_n ^ flag_v;
            4'd4:    taken = !(flag_n ^ flag_v);
            default: taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register, loaded on the acknowledged fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_we) begin
            ir <= ir_in;
        end
    end

    // Wait counter: counts unacknowledged request cycles within one FETCH/MEM
    // visit and clears whenever the visit ends or an ack arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == FETCH || state == MEM) && mem_req && !mem_ack
                     && state_next == state) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state and output decode; reset masks every output.
    always_comb begin
        state_next = state;
        a_sel      = '0;
        b_sel      = '0;
        d_sel      = '0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        alu_op     = 4'b0000;
        alu_b_imm  = 1'b0;
        psr_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        addr_sel   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        fault      = 1'b0;
        state_o    = state;

        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                addr_sel = 1'b0;
                if (mem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                case (fmt)
                    2'b00:   state_next = ALU;
                    2'b11:   state_next = BRANCH;
                    default: state_next = MEM;
                endcase
            end
            ALU: begin
                a_sel      = rs1;
                b_sel      = rs2;
                d_sel      = rd;
                alu_op     = op;
                alu_b_imm  = imm;
                rf_we      = 1'b1;
                wb_sel     = 1'b0;
                psr_we     = op[3];
                state_next = PCINC;
            end
            MEM: begin
                a_sel     = rs1;
                b_sel     = rd;
                alu_op    = 4'b0000;
                alu_b_imm = 1'b1;
                addr_sel  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = (fmt == 2'b10);
                if (mem_ack) begin
                    if (fmt == 2'b01) begin
                        rf_we  = 1'b1;
                        wb_sel = 1'b1;
                        d_sel  = rd;
                    end
                    state_next = PCINC;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            BRANCH: begin
                if (taken) begin
                    pc_we      = 1'b1;
                    pc_sel     = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = PCINC;
                end
            end
            PCINC: begin
                pc_we      = 1'b1;
                pc_sel     = 1'b0;
                state_next = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (rst) begin
            a_sel     = '0;
            b_sel     = '0;
            d_sel     = '0;
            rf_we     = 1'b0;
            wb_sel    = 1'b0;
            alu_op    = 4'b0000;
            alu_b_imm = 1'b0;
            psr_we    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = 1'b0;
            addr_sel  = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            fault     = 1'b0;
            state_o   = 7'b0000000;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model predicts every
// output each cycle, and directed literal checks pin the model to the
// documented examples. A second instance checks the widened field layout.
module tb_control_sequencer;

    localparam int IR_W     = 16;
    localparam int REG_AW   = 3;
    localparam int WAIT_MAX = 8;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_ALU    = 2;
    localparam int P_MEM    = 3;
    localparam int P_BRANCH = 4;
    localparam int P_PCINC  = 5;
    localparam int P_FAULT  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] ir_in;
    logic [3:0]  status;
    logic        mem_ack;

    logic [2:0]  a_sel, b_sel, d_sel;
    logic        rf_we, wb_sel, alu_b_imm, psr_we, ir_we, pc_we, pc_sel;
    logic        addr_sel, mem_req, mem_we, fault;
    logic [3:0]  alu_op;
    logic [6:0]  state_o;

    control_sequencer #(.IR_W(IR_W), .REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX)) u_dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .status(status), .mem_ack(mem_ack),
        .a_sel(a_sel), .b_sel(b_sel), .d_sel(d_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .alu_b_imm(alu_b_imm), .psr_we(psr_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .addr_sel(addr_sel), .mem_req(mem_req),
        .mem_we(mem_we), .fault(fault), .state_o(state_o)
    );

    // Wide-field instance: ALU instruction rd=3 rs1=1 rs2=2 op=1, always acked.
    localparam logic [18:0] IR_WIDE = {2'b00, 4'b0001, 1'b0, 4'd3, 4'd1, 4'd2};
    logic [18:0] ir_in_w;
    logic [3:0]  status_w;
    logic        mem_ack_w;
    logic [3:0]  a_sel_w, b_sel_w, d_sel_w;
    logic        rf_we_w, wb_sel_w, alu_b_imm_w, psr_we_w, ir_we_w, pc_we_w, pc_sel_w;
    logic        addr_sel_w, mem_req_w, mem_we_w, fault_w;
    logic [3:0]  alu_op_w;
    logic [6:0]  state_o_w;

    assign ir_in_w   = IR_WIDE;
    assign status_w  = 4'b0000;
    assign mem_ack_w = 1'b1;

    control_sequencer #(.IR_W(19), .REG_AW(4), .WAIT_MAX(WAIT_MAX)) u_dut_wide (
        .clk(clk), .rst(rst), .ir_in(ir_in_w), .status(status_w), .mem_ack(mem_ack_w),
        .a_sel(a_sel_w), .b_sel(b_sel_w), .d_sel(d_sel_w), .rf_we(rf_we_w), .wb_sel(wb_sel_w),
        .alu_op(alu_op_w), .alu_b_imm(alu_b_imm_w), .psr_we(psr_we_w), .ir_we(ir_we_w),
        .pc_we(pc_we_w), .pc_sel(pc_sel_w), .addr_sel(addr_sel_w), .mem_req(mem_req_w),
        .mem_we(mem_we_w), .fault(fault_w), .state_o(state_o_w)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = P_FETCH;
    logic [15:0] m_ir    = 16'h0000;
    int          m_wait  = 0;

    function automatic bit br_taken(input int op, input logic [3:0] st);
        bit n, z, v;
        n = st[3];
        z = st[2];
        v = st[1];
        case (op)
            0:       return 1'b1;
            1:       return z;
            2:       return !z;
            3:       return n ^ v;
            4:       return !(n ^ v);
            default: return 1'b0;
        endcase
    endfunction

    // Unacknowledged request cycles including the current one.
    function automatic int next_wait();
        if ((m_phase == P_FETCH || m_phase == P_MEM) && !mem_ack) return m_wait + 1;
        return 0;
    endfunction

    function automatic int next_phase();
        int fmt, op;
        fmt = int'(m_ir) / 16384;
        op  = (int'(m_ir) / 1024) % 16;
        case (m_phase)
            P_FETCH, P_MEM: begin
                if (mem_ack) return (m_phase == P_FETCH) ? P_DECODE : P_PCINC;
                if (WAIT_MAX != 0 && next_wait() == WAIT_MAX) return P_FAULT;
                return m_phase;
            end
            P_DECODE: begin
                if (fmt == 0) return P_ALU;
                if (fmt == 3) return P_BRANCH;
                return P_MEM;
            end
            P_ALU:    return P_PCINC;
            P_BRANCH: return br_taken(op, status) ? P_FETCH : P_PCINC;
            P_PCINC:  return P_FETCH;
            default:  return P_FAULT;
        endcase
    endfunction

    function automatic logic [30:0] model_out();
        int fmt, op, iv, rd, rs1, rs2;
        int a, b, d, alu;
        bit rf, wb, imm, psr, irwe, pcwe, pcsel, addr, req, we, flt;
        if (rst) return '0;
        fmt = int'(m_ir) / 16384;
        op  = (int'(m_ir) / 1024) % 16;
        iv  = (int'(m_ir) / 512) % 2;
        rd  = (int'(m_ir) / 64) % 8;
        rs1 = (int'(m_ir) / 8) % 8;
        rs2 = int'(m_ir) % 8;
        a = 0; b = 0; d = 0; alu = 0;
        rf = 0; wb = 0; imm = 0; psr = 0; irwe = 0; pcwe = 0; pcsel = 0;
        addr = 0; req = 0; we = 0; flt = 0;
        case (m_phase)
            P_FETCH: begin
                req  = 1;
                irwe = mem_ack;
            end
            P_ALU: begin
                a = rs1; b = rs2; d = rd; alu = op;
                imm = (iv != 0); rf = 1; psr = (op >= 8);
            end
            P_MEM: begin
                a = rs1; b = rd; imm = 1; addr = 1; req = 1;
                we = (fmt == 2);
                if (fmt == 1 && mem_ack) begin
                    rf = 1; wb = 1; d = rd;
                end
            end
            P_BRANCH: begin
                if (br_taken(op, status)) begin
                    pcwe = 1; pcsel = 1;
                end
            end
            P_PCINC: pcwe = 1;
            P_FAULT: flt = 1;
            default: ;
        endcase
        return {3'(a), 3'(b), 3'(d), rf, wb, 4'(alu), imm, psr, irwe, pcwe, pcsel,
                addr, req, we, flt, 7'(1 << m_phase)};
    endfunction

    initial begin : model_step
        int np, nw;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = P_FETCH;
                m_ir    = 16'h0000;
                m_wait  = 0;
            end else begin
                np = next_phase();
                nw = next_wait();
                if (m_phase == P_FETCH && mem_ack) m_ir = ir_in;
                m_wait  = (np == m_phase) ? nw : 0;
                m_phase = np;
            end
        end
    end

    logic [30:0] dut_vec;
    assign dut_vec = {a_sel, b_sel, d_sel, rf_we, wb_sel, alu_op, alu_b_imm, psr_we, ir_we,
                      pc_we, pc_sel, addr_sel, mem_req, mem_we, fault, state_o};

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cycle_outputs", 32'(dut_vec), 32'(model_out()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Called in a FETCH cycle; returns in the DECODE cycle.
    task automatic fetch(input logic [15:0] ins);
        ir_in   = ins;
        mem_ack = 1'b1;
        neg();
        chk("fetch_state", 32'(state_o), 32'h01);
        step();
        mem_ack = 1'b0;
    endtask

    int          br_op  [6] = '{0, 2, 3, 4, 5, 15};
    logic [3:0]  br_st  [6] = '{4'b0000, 4'b0000, 4'b1000, 4'b1010, 4'b1111, 4'b1111};
    logic        br_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin : stim
        logic [15:0] ins;
        rst     = 1'b1;
        ir_in   = 16'h0000;
        status  = 4'b0000;
        mem_ack = 1'b0;
        step();
        step();
        neg();
        chk("rst_state_o", 32'(state_o), 32'h00);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_fault",   32'(fault),   32'd0);
        step();

        // ALU 04CA, first cycle out of reset
        rst     = 1'b0;
        ir_in   = 16'h04CA;
        mem_ack = 1'b1;
        neg();
        chk("post_rst_fetch", 32'(state_o), 32'h01);
        chk("post_rst_req",   32'(mem_req), 32'd1);
        chk("fetch_ir_we",    32'(ir_we),   32'd1);
        step();
        mem_ack = 1'b0;
        neg();
        chk("decode_state", 32'(state_o), 32'h02);
        step();
        neg();
        chk("alu_a_sel",  32'(a_sel),  32'd1);
        chk("alu_b_sel",  32'(b_sel),  32'd2);
        chk("alu_d_sel",  32'(d_sel),  32'd3);
        chk("alu_op",     32'(alu_op), 32'd1);
        chk("alu_rf_we",  32'(rf_we),  32'd1);
        chk("alu_psr_we", 32'(psr_we), 32'd0);
        chk("wide_state", 32'(state_o_w), 32'h04);
        chk("wide_a_sel", 32'(a_sel_w),   32'd1);
        chk("wide_b_sel", 32'(b_sel_w),   32'd2);
        chk("wide_d_sel", 32'(d_sel_w),   32'd3);
        chk("wide_alu_op", 32'(alu_op_w), 32'd1);
        chk("wide_rf_we", 32'(rf_we_w),   32'd1);
        step();
        neg();
        chk("pcinc_state",  32'(state_o), 32'h20);
        chk("pcinc_pc_we",  32'(pc_we),   32'd1);
        chk("pcinc_pc_sel", 32'(pc_sel),  32'd0);
        step();

        // Load 4350 with ack delayed 3 cycles
        fetch(16'h4350);
        step();
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("ld_wait_state", 32'(state_o), 32'h08);
            chk("ld_wait_req",   32'(mem_req), 32'd1);
            chk("ld_wait_we",    32'(mem_we),  32'd0);
            chk("ld_wait_a_sel", 32'(a_sel),   32'd2);
            chk("ld_wait_rf_we", 32'(rf_we),   32'd0);
            step();
        end
        mem_ack = 1'b1;
        neg();
        chk("ld_ack_rf_we",  32'(rf_we),  32'd1);
        chk("ld_ack_wb_sel", 32'(wb_sel), 32'd1);
        chk("ld_ack_d_sel",  32'(d_sel),  32'd5);
        step();
        mem_ack = 1'b0;
        step();

        // Store 8350, zero-wait ack
        fetch(16'h8350);
        step();
        mem_ack = 1'b1;
        neg();
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_b_sel",  32'(b_sel),  32'd5);
        chk("st_rf_we",  32'(rf_we),  32'd0);
        step();
        mem_ack = 1'b0;
        step();

        // ALU with op[3]=1, imm, rd=7 rs1=6 rs2=5
        fetch(16'h23F5);
        step();
        neg();
        chk("alu2_psr_we", 32'(psr_we),    32'd1);
        chk("alu2_imm",    32'(alu_b_imm), 32'd1);
        chk("alu2_d_sel",  32'(d_sel),     32'd7);
        chk("alu2_op",     32'(alu_op),    32'd8);
        step();
        step();

        // Branch C400 taken with Z=1, then untaken with Z=0
        status = 4'b0100;
        fetch(16'hC400);
        step();
        neg();
        chk("br_tk_pc_we",  32'(pc_we),  32'd1);
        chk("br_tk_pc_sel", 32'(pc_sel), 32'd1);
        step();
        status = 4'b0000;
        fetch(16'hC400);
        step();
        neg();
        chk("br_nt_pc_we", 32'(pc_we), 32'd0);
        step();
        neg();
        chk("br_nt_next", 32'(state_o), 32'h20);
        step();

        for (int k = 0; k < 6; k++) begin
            status = br_st[k];
            ins    = 16'hC000 | (16'(br_op[k]) << 10);
            fetch(ins);
            step();
            neg();
            chk("br_cond", 32'(pc_we), 32'(br_exp[k]));
            step();
            if (!br_exp[k]) step();
        end
        status = 4'b0000;

        // Ack arrives on the 8th request cycle: no fault
        ir_in   = 16'h04CA;
        mem_ack = 1'b0;
        for (int k = 1; k < 8; k++) step();
        mem_ack = 1'b1;
        neg();
        chk("late_ack_state", 32'(state_o), 32'h01);
        step();
        mem_ack = 1'b0;
        neg();
        chk("late_ack_fault",  32'(fault),   32'd0);
        chk("late_ack_decode", 32'(state_o), 32'h02);
        step();
        step();
        step();

        // No ack at all: fault after the 8th request cycle, sticky
        for (int k = 1; k <= 8; k++) begin
            neg();
            chk("to_req", 32'(mem_req), 32'd1);
            step();
        end
        neg();
        chk("to_state", 32'(state_o), 32'h40);
        chk("to_fault", 32'(fault),   32'd1);
        mem_ack = 1'b1;
        step();
        step();
        neg();
        chk("to_sticky", 32'(fault), 32'd1);
        step();
        mem_ack = 1'b0;

        // Reset during a store in MEM
        rst = 1'b1;
        step();
        rst = 1'b0;
        fetch(16'h8350);
        step();
        neg();
        chk("st_pre_rst_we", 32'(mem_we), 32'd1);
        step();
        rst = 1'b1;
        neg();
        chk("rst_mid_req",   32'(mem_req), 32'd0);
        chk("rst_mid_we",    32'(mem_we),  32'd0);
        step();
        rst = 1'b0;
        neg();
        chk("rst_mid_after", 32'(state_o), 32'h01);
        step();

        // Timeout while waiting in MEM
        fetch(16'h4350);
        step();
        for (int k = 1; k <= 8; k++) step();
        neg();
        chk("mem_to_state", 32'(state_o), 32'h40);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
